// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronises, latches and masks IRQ lines into one held request.
// Optional macro IRQ_EDGE_MODE_EN adds per-line rising-edge latching via register 19.
module ext_int_ctrl #(
    parameter int NUM_IRQ        = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic [NUM_IRQ-1:0]        i_irq,
    input  logic                      i_int_taken,
    input  logic                      i_eret,
    input  logic                      i_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0]     i_din,
    output logic [DATA_WIDTH-1:0]     o_dout,
    output logic                      o_ext_int,
    output logic [3:0]                o_irq_id
);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_EN   = REG_ADDR_WIDTH'(16);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_PEND = REG_ADDR_WIDTH'(17);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ID   = REG_ADDR_WIDTH'(18);
`ifdef IRQ_EDGE_MODE_EN
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_EDGE = REG_ADDR_WIDTH'(19);
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    state_t                state, state_nxt;
    logic                  ext_int_nxt;
    logic [3:0]            irq_id_nxt;
    logic [3:0]            win_id;
    logic [NUM_IRQ-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0]    irq_s;
    logic [NUM_IRQ-1:0]    pend, pend_nxt;
    logic [NUM_IRQ-1:0]    irq_en;
    logic [NUM_IRQ-1:0]    req, req_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en_reg;
    logic                  unused_din;

    function automatic logic [3:0] highest_id(input logic [NUM_IRQ-1:0] v);
        logic [3:0] id;
        id = 4'd0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (v[k]) id = 4'(k);
        end
        return id;
    endfunction

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= i_irq;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign irq_s      = sync_q[SYNC_STAGES-1];
    assign wr_en_reg  = i_en && (i_address == ADDR_EN);
    assign unused_din = ^i_din;

`ifdef IRQ_EDGE_MODE_EN
    logic [NUM_IRQ-1:0] edge_mode, irq_s_prev, w1c, taken_clr, rise;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            irq_s_prev <= '0;
            edge_mode  <= '0;
        end else begin
            irq_s_prev <= irq_s;
            if (i_en && (i_address == ADDR_EDGE)) edge_mode <= i_din[NUM_IRQ-1:0];
        end
    end

    // A new rising edge is OR-ed in last so it beats a same-cycle W1C or int_taken clear.
    always_comb begin
        w1c       = (i_en && (i_address == ADDR_PEND)) ? i_din[NUM_IRQ-1:0] : '0;
        taken_clr = (state == REQ && i_int_taken) ? (NUM_IRQ'(1) << o_irq_id) : '0;
        rise      = irq_s & ~irq_s_prev;
        pend_nxt  = (edge_mode & ((pend & ~w1c & ~taken_clr) | rise)) | (~edge_mode & irq_s);
    end
`else
    assign pend_nxt = irq_s;
`endif

    assign req     = pend & irq_en;
    assign req_nxt = pend_nxt & irq_en;
    assign win_id  = highest_id(req);

    always_comb begin
        rd_data = '0;
        case (i_address)
            ADDR_EN:   rd_data[NUM_IRQ-1:0] = irq_en;
            ADDR_PEND: rd_data[NUM_IRQ-1:0] = pend;
            ADDR_ID:   rd_data[5:0]         = {state, o_irq_id};
`ifdef IRQ_EDGE_MODE_EN
            ADDR_EDGE: rd_data[NUM_IRQ-1:0] = edge_mode;
`endif
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            pend   <= '0;
            irq_en <= '0;
            o_dout <= '0;
        end else begin
            pend   <= pend_nxt;
            o_dout <= rd_data;
            if (wr_en_reg) irq_en <= i_din[NUM_IRQ-1:0];
        end
    end

    // Withdrawal looks at the pending vector being loaded this edge, so a dropped line
    // releases the request on the same edge its pending bit clears.
    always_comb begin
        state_nxt   = state;
        ext_int_nxt = o_ext_int;
        irq_id_nxt  = o_irq_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt   = REQ;
                    ext_int_nxt = 1'b1;
                    irq_id_nxt  = win_id;
                end
            end
            REQ: begin
                if (i_int_taken) begin
                    state_nxt   = SERVICE;
                    ext_int_nxt = 1'b0;
                end else if (req_nxt == '0) begin
                    state_nxt   = IDLE;
                    ext_int_nxt = 1'b0;
                end else begin
                    irq_id_nxt  = win_id;
                end
            end
            SERVICE: begin
                ext_int_nxt = 1'b0;
                if (i_eret) state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                ext_int_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= IDLE;
            o_ext_int <= 1'b0;
            o_irq_id  <= 4'd0;
        end else begin
            state     <= state_nxt;
            o_ext_int <= ext_int_nxt;
            o_irq_id  <= irq_id_nxt;
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: directed scenarios plus randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_ext_int_ctrl;
    localparam int S = 2;
`ifdef IRQ_EDGE_MODE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  irq = '0;
    logic        int_taken = 1'b0;
    logic        eret = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        ext_int;
    logic [3:0]  irq_id;

    int tests = 0;
    int fails = 0;

    ext_int_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(S), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clk(clk), .i_arst(rst), .i_irq(irq), .i_int_taken(int_taken), .i_eret(eret),
        .i_en(wen), .i_address(addr), .i_din(din), .o_dout(dout), .o_ext_int(ext_int),
        .o_irq_id(irq_id)
    );

    always #5 clk = ~clk;

    // Reference model: state 0=idle, 1=requesting, 2=in service.
    logic [7:0]  m_hist [S];
    logic [7:0]  m_prev, m_pend, m_en, m_edge;
    int          m_state;
    logic        m_ext;
    logic [3:0]  m_id;
    logic [31:0] m_dout;

    function automatic logic [3:0] top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] s, req, newp;
        logic [3:0] win;
        if (rst) begin
            for (int i = 0; i < S; i++) m_hist[i] = '0;
            m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0;
            m_state = 0; m_ext = 1'b0; m_id = '0; m_dout = '0;
        end else begin
            s   = m_hist[S-1];
            req = m_pend & m_en;
            win = top_bit(req);
            for (int i = 0; i < 8; i++) begin
                if (m_edge[i]) begin
                    newp[i] = m_pend[i];
                    if (wen && addr == 5'd17 && din[i]) newp[i] = 1'b0;
                    if (m_state == 1 && int_taken && int'(m_id) == i) newp[i] = 1'b0;
                    if (s[i] && !m_prev[i]) newp[i] = 1'b1;
                end else begin
                    newp[i] = s[i];
                end
            end
            case (addr)
                5'd16:   m_dout = {24'd0, m_en};
                5'd17:   m_dout = {24'd0, m_pend};
                5'd18:   m_dout = 32'(m_state * 16 + int'(m_id));
                5'd19:   m_dout = {24'd0, m_edge};
                default: m_dout = '0;
            endcase
            case (m_state)
                0: if (req != 0) begin m_state = 1; m_ext = 1'b1; m_id = win; end
                1: begin
                    if (int_taken) begin m_state = 2; m_ext = 1'b0; end
                    else if ((newp & m_en) == 0) begin m_state = 0; m_ext = 1'b0; end
                    else m_id = win;
                end
                default: if (eret) m_state = 0;
            endcase
            if (wen && addr == 5'd16) m_en = din[7:0];
            if (EDGE_EN && wen && addr == 5'd19) m_edge = din[7:0];
            m_pend = newp;
            m_prev = s;
            for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = irq;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model_ext_int", {31'd0, ext_int}, {31'd0, m_ext});
        chk("model_irq_id", {28'd0, irq_id}, {28'd0, m_id});
        chk("model_dout", dout, m_dout);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; din = d;
        tick();
        wen = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ext_int", {31'd0, ext_int}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_irq_id", {28'd0, irq_id}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;

        // Reset with all lines high
        irq = 8'hFF;
        do_reset();
        addr = 5'd18;
        tick();
        chk("reset_id_reg", dout, 32'd0);
        chk("reset_no_req", {31'd0, ext_int}, 32'd0);

        // Level line, latency, take and re-request after eret
        irq = 8'h00; do_reset();
        wr(5'd16, 32'h04);
        irq = 8'h04;
        tick(); tick(); tick();
        chk("lvl_ext_early", {31'd0, ext_int}, 32'd0);
        tick();
        chk("lvl_ext", {31'd0, ext_int}, 32'd1);
        chk("lvl_id", {28'd0, irq_id}, 32'd2);
        int_taken = 1'b1; tick(); int_taken = 1'b0;
        chk("lvl_taken", {31'd0, ext_int}, 32'd0);
        addr = 5'd18; tick();
        chk("lvl_id_reg", dout, 32'h22);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("lvl_eret_edge", {31'd0, ext_int}, 32'd0);
        tick();
        chk("lvl_rereq", {31'd0, ext_int}, 32'd1);

        // Priority
        irq = 8'h00; do_reset();
        wr(5'd16, 32'hFF);
        irq = 8'h42;
        repeat (4) tick();
        chk("prio_ext", {31'd0, ext_int}, 32'd1);
        chk("prio_id6", {28'd0, irq_id}, 32'd6);
        int_taken = 1'b1; tick(); int_taken = 1'b0;
        irq = 8'h02;
        repeat (3) tick();
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        chk("prio_next_ext", {31'd0, ext_int}, 32'd1);
        chk("prio_id1", {28'd0, irq_id}, 32'd1);

        // Withdraw
        irq = 8'h00; do_reset();
        wr(5'd16, 32'h08);
        irq = 8'h08;
        repeat (4) tick();
        chk("wd_req", {31'd0, ext_int}, 32'd1);
        chk("wd_id", {28'd0, irq_id}, 32'd3);
        irq = 8'h00;
        tick(); tick();
        chk("wd_hold", {31'd0, ext_int}, 32'd1);
        tick();
        chk("wd_drop", {31'd0, ext_int}, 32'd0);
        addr = 5'd18; tick();
        chk("wd_state_idle", dout, 32'h03);

        // Masking and eret while idle
        irq = 8'h00; do_reset();
        irq = 8'h20;
        repeat (6) tick();
        chk("mask_none", {31'd0, ext_int}, 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        addr = 5'd18; tick();
        chk("eret_idle_id", dout, 32'd0);
        wr(5'd16, 32'h20);
        chk("mask_wr_edge", {31'd0, ext_int}, 32'd0);
        tick();
        chk("mask_on", {31'd0, ext_int}, 32'd1);
        chk("mask_id", {28'd0, irq_id}, 32'd5);

`ifdef IRQ_EDGE_MODE_EN
        // Edge-mode latching, int_taken clear, set beats W1C
        irq = 8'h00; do_reset();
        wr(5'd16, 32'h01);
        wr(5'd19, 32'h01);
        addr = 5'd17;
        irq = 8'h01; tick(); irq = 8'h00;
        repeat (3) tick();
        chk("edge_ext", {31'd0, ext_int}, 32'd1);
        chk("edge_pend", dout, 32'h01);
        int_taken = 1'b1; tick(); int_taken = 1'b0;
        tick();
        chk("edge_taken_clr", dout, 32'h00);
        irq = 8'h01; tick(); irq = 8'h00; tick();
        wr(5'd17, 32'h01);
        addr = 5'd17; tick();
        chk("edge_set_wins", dout, 32'h01);
`else
        // Without edge mode: register 19 absent, W1C ineffective
        irq = 8'h00; do_reset();
        wr(5'd19, 32'hFF);
        addr = 5'd19; tick();
        chk("edge_reg_absent", dout, 32'd0);
        irq = 8'h01;
        repeat (3) tick();
        wr(5'd17, 32'h01);
        addr = 5'd17; tick();
        chk("w1c_level_kept", dout, 32'h01);
`endif

        // Randomized traffic with a mid-run reset
        irq = 8'h00; do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            if ($urandom_range(0, 7) == 0) irq = 8'($urandom);
            int_taken = ($urandom_range(0, 3) == 0);
            eret      = ($urandom_range(0, 5) == 0);
            wen       = ($urandom_range(0, 5) == 0);
            addr      = 5'($urandom_range(14, 20));
            din       = $urandom;
            tick();
        end
        wen = 1'b0; int_taken = 1'b0; eret = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
